// File: rtl/tdm_selector41_scan_pkg.sv
// Shared types and constants for the 4-channel time-division selector.
package tdm_selector41_scan_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CH_W = 2;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SLOT = 1'b1;

  typedef enum logic {
    StIdle = ST_IDLE,
    StSlot = ST_SLOT
  } state_e;

  typedef logic [CH_W-1:0] ch_t;

endpackage

// File: rtl/tdm_selector41_scan_if.sv
// Channel data, control and select/data outputs of the time-division selector.
interface tdm_selector41_scan_if #(
  parameter int unsigned W = 1
);
  logic         iEn;
  logic [3:0]   iMask;
  logic [W-1:0] iD0;
  logic [W-1:0] iD1;
  logic [W-1:0] iD2;
  logic [W-1:0] iD3;
  logic [W-1:0] oZ;
  logic         oS1;
  logic         oS0;
  logic         oValid;
  logic         oFrame;

  modport master (
    output iEn, iMask, iD0, iD1, iD2, iD3,
    input  oZ, oS1, oS0, oValid, oFrame
  );

  modport slave (
    input  iEn, iMask, iD0, iD1, iD2, iD3,
    output oZ, oS1, oS0, oValid, oFrame
  );
endinterface

// File: rtl/tdm_selector41_scan_next_chan_find.sv
// Circular next-enabled-channel search plus lowest-enabled-channel lookup.
module next_chan_find
  import tdm_selector41_scan_pkg::*;
(
  input  logic [NCH-1:0] mask_i,
  input  ch_t            cur_i,
  output ch_t            nxt_o,
  output logic           wrap_o,
  output ch_t            first_o
);

  ch_t cand;

  always_comb begin
    first_o = '0;
    nxt_o   = cur_i;
    cand    = '0;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (mask_i[k]) first_o = ch_t'(k);
    end
    // Scan offsets high to low so the nearest enabled channel wins.
    for (int k = int'(NCH) - 1; k >= 1; k--) begin
      cand = cur_i + ch_t'(k);
      if (mask_i[cand]) nxt_o = cand;
    end
  end

  assign wrap_o = (nxt_o <= cur_i);

endmodule

// File: rtl/tdm_selector41_scan.sv
// Round-robin 4-to-1 time-division selector: holds each enabled channel for DWELL
// cycles, drives the matching select code, and flags the first cycle of each frame.
module tdm_selector41_scan
  import tdm_selector41_scan_pkg::*;
#(
  parameter int unsigned W     = 1,
  parameter int unsigned DWELL = 2
) (
  input logic                   iClk,
  input logic                   iRst_n,
  tdm_selector41_scan_if.slave  bus
);

  localparam logic [3:0] DwellM1 = 4'(DWELL - 1);

  state_e         state_q;
  logic [NCH-1:0] mask_q;
  ch_t            ptr_q;
  logic [3:0]     cnt_q;
  logic [W-1:0]   z_q;
  ch_t            sel_q;
  logic           valid_q;
  logic           frame_q;

  ch_t  nxt;
  logic wrap;
  ch_t  first_new;
  ch_t  first_cur;
  ch_t  nxt_new;
  logic wrap_new;
  logic start_ok;

  next_chan_find u_adv (
    .mask_i  (mask_q),
    .cur_i   (ptr_q),
    .nxt_o   (nxt),
    .wrap_o  (wrap),
    .first_o (first_cur)
  );

  next_chan_find u_new (
    .mask_i  (bus.iMask),
    .cur_i   (ptr_q),
    .nxt_o   (nxt_new),
    .wrap_o  (wrap_new),
    .first_o (first_new)
  );

  logic unused_find;
  assign unused_find = ^{first_cur, nxt_new, wrap_new};

  function automatic logic [W-1:0] pick(ch_t ch, logic [W-1:0] d0, logic [W-1:0] d1,
                                        logic [W-1:0] d2, logic [W-1:0] d3);
    pick = d0;
    unique case (ch)
      2'd0: pick = d0;
      2'd1: pick = d1;
      2'd2: pick = d2;
      2'd3: pick = d3;
    endcase
  endfunction

  logic [W-1:0] d_nxt;
  logic [W-1:0] d_first;

  assign d_nxt    = pick(nxt, bus.iD0, bus.iD1, bus.iD2, bus.iD3);
  assign d_first  = pick(first_new, bus.iD0, bus.iD1, bus.iD2, bus.iD3);
  assign start_ok = bus.iEn && (bus.iMask != '0);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            mask_q  <= bus.iMask;
            ptr_q   <= first_new;
            sel_q   <= first_new;
            z_q     <= d_first;
            valid_q <= 1'b1;
            frame_q <= 1'b1;
            cnt_q   <= DwellM1;
            state_q <= StSlot;
          end
        end
        StSlot: begin
          if (cnt_q != '0) begin
            cnt_q   <= cnt_q - 4'd1;
            frame_q <= 1'b0;
          end else if (!wrap) begin
            // Mid-frame: iEn/iMask are ignored so a started frame always completes.
            ptr_q   <= nxt;
            sel_q   <= nxt;
            z_q     <= d_nxt;
            frame_q <= 1'b0;
            cnt_q   <= DwellM1;
          end else if (!start_ok) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            z_q     <= '0;
            sel_q   <= '0;
            frame_q <= 1'b0;
          end else begin
            mask_q  <= bus.iMask;
            ptr_q   <= first_new;
            sel_q   <= first_new;
            z_q     <= d_first;
            frame_q <= 1'b1;
            cnt_q   <= DwellM1;
          end
        end
      endcase
    end
  end

  assign bus.oZ     = z_q;
  assign bus.oS1    = sel_q[1];
  assign bus.oS0    = sel_q[0];
  assign bus.oValid = valid_q;
  assign bus.oFrame = frame_q;

endmodule

// File: tb/tb_tdm_selector41_scan.sv
// Self-checking bench: directed scenarios plus randomized traffic against a frame-schedule model.
module tb_tdm_selector41_scan;

  localparam int unsigned W     = 4;
  localparam int unsigned DWELL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         en;
  logic [3:0]   mask;
  logic [W-1:0] d [4];

  int checks = 0;
  int errors = 0;

  tdm_selector41_scan_if #(.W(W)) bus ();

  assign bus.iEn   = en;
  assign bus.iMask = mask;
  assign bus.iD0   = d[0];
  assign bus.iD1   = d[1];
  assign bus.iD2   = d[2];
  assign bus.iD3   = d[3];

  tdm_selector41_scan #(.W(W), .DWELL(DWELL)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  logic [7:0] obs;
  assign obs = {bus.oValid, bus.oFrame, bus.oS1, bus.oS0, bus.oZ};

  // Reference model: a frame is a queue of enabled channels, each held DWELL cycles.
  bit           m_active = 1'b0;
  int           m_left   = 0;
  int           m_sched[$];
  logic         e_v = 1'b0;
  logic         e_f = 1'b0;
  logic [1:0]   e_s = 2'b00;
  logic [W-1:0] e_z = '0;
  logic [7:0]   exp_w;
  assign exp_w = {e_v, e_f, e_s, e_z};

  function automatic void load(int ch, logic frame);
    e_v    = 1'b1;
    e_f    = frame;
    e_s    = 2'(ch);
    e_z    = d[ch];
    m_left = int'(DWELL) - 1;
  endfunction

  function automatic void model_step();
    if (!rst_n) begin
      m_active = 1'b0;
      m_sched.delete();
      {e_v, e_f, e_s, e_z} = '0;
    end else if (m_active && m_left > 0) begin
      m_left--;
      e_f = 1'b0;
    end else if (m_active && m_sched.size() > 0) begin
      load(m_sched.pop_front(), 1'b0);
    end else if (en && mask != 4'b0) begin
      m_sched.delete();
      for (int k = 0; k < 4; k++) if (mask[k]) m_sched.push_back(k);
      load(m_sched.pop_front(), 1'b1);
      m_active = 1'b1;
    end else begin
      m_active = 1'b0;
      {e_v, e_f, e_s, e_z} = '0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    mask  = 4'b0;
    d     = '{4'hA, 4'hB, 4'hC, 4'hD};
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    mask  = 4'hF;
    d     = '{4'hA, 4'hB, 4'hC, 4'hD};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset c%0d: got %b want %b", i, obs, 8'h00);
      end
    end
    rst_n = 1'b1;
    en    = 1'b0;
  endtask

  task automatic test_full_scan();
    logic [7:0] plan;
    do_reset();
    mask = 4'hF;
    en   = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      plan = {1'b1, 1'(i % 8 == 0), 2'((i / 2) % 4), d[(i / 2) % 4]};
      checks++;
      if (obs !== plan) begin
        errors++;
        $display("FAIL full_scan c%0d: got %b want %b", i, obs, plan);
      end
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL full_scan_model c%0d: got %b want %b", i, obs, exp_w);
      end
    end
  endtask

  task automatic test_sparse();
    logic [7:0] plan;
    int         ch;
    do_reset();
    mask = 4'b1010;
    en   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      ch   = ((i / 2) % 2 == 0) ? 1 : 3;
      plan = {1'b1, 1'(i % 4 == 0), 2'(ch), d[ch]};
      checks++;
      if (obs !== plan) begin
        errors++;
        $display("FAIL sparse c%0d: got %b want %b", i, obs, plan);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] plan;
    do_reset();
    mask = 4'b0100;
    en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      plan = {1'b1, 1'(i % 2 == 0), 2'd2, (i < 2) ? 4'hC : 4'h3};
      checks++;
      if (obs !== plan) begin
        errors++;
        $display("FAIL single c%0d: got %b want %b", i, obs, plan);
      end
      if (i == 0) d[2] = 4'h3;
    end
  endtask

  task automatic test_disable();
    logic [7:0] plan;
    do_reset();
    mask = 4'hF;
    en   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      plan = (i < 8) ? {1'b1, 1'(i == 0), 2'(i / 2), d[i / 2]} : 8'h00;
      checks++;
      if (obs !== plan) begin
        errors++;
        $display("FAIL disable c%0d: got %b want %b", i, obs, plan);
      end
      if (i == 2) en = 1'b0;
    end
  endtask

  task automatic test_mask_change();
    logic [7:0] plan;
    do_reset();
    mask = 4'hF;
    en   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      plan = (i < 8) ? {1'b1, 1'(i == 0), 2'(i / 2), d[i / 2]}
                     : {1'b1, 1'(i % 2 == 0), 2'd0, 4'hA};
      checks++;
      if (obs !== plan) begin
        errors++;
        $display("FAIL mask_change c%0d: got %b want %b", i, obs, plan);
      end
      if (i == 1) mask = 4'b0001;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mask = 4'hF;
    en   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL reset_mid_pre c%0d: got %b want %b", i, obs, exp_w);
      end
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_hit: got %b want %b", obs, 8'h00);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 1'b1, 2'd0, 4'hA}) begin
      errors++;
      $display("FAIL reset_mid_restart: got %b want %b", obs, {1'b1, 1'b1, 2'd0, 4'hA});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL reset_mid_post c%0d: got %b want %b", i, obs, exp_w);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      en    = ($urandom_range(0, 7) != 0);
      mask  = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) d[k] = 4'($urandom_range(0, 15));
      step();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL random c%0d: got %b want %b", i, obs, exp_w);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mask  = 4'b0;
    d     = '{4'hA, 4'hB, 4'hC, 4'hD};
    test_reset();
    test_full_scan();
    test_sparse();
    test_single();
    test_disable();
    test_mask_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
